// File: rtl/systolic_feeder_2x2.sv
// rtl/systolic_feeder_2x2.sv - input skew feeder for the 2x2 systolic MAC array
// Buffers 2-element vectors in a FIFO and presents them to the array rows with a one-cycle diagonal skew.
module systolic_feeder_2x2 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       in_vec,
  input  logic                     in_last,
  input  logic                     stall,
  output logic [WIDTH-1:0]         a0_out,
  output logic                     a0_valid,
  output logic [WIDTH-1:0]         a1_out,
  output logic                     a1_valid,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] dly;
  logic             dly_v;
  logic             dly_last;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [2*WIDTH:0] head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count    = wptr - rptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (wptr == rptr);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = !stall && !empty;
  assign head     = mem[rptr[AW-1:0]];
  assign busy     = (count != '0) || dly_v || a0_valid || a1_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {in_last, in_vec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      a0_out   <= '0;
      a0_valid <= 1'b0;
      a1_out   <= '0;
      a1_valid <= 1'b0;
      dly      <= '0;
      dly_v    <= 1'b0;
      dly_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (stall) begin
        done <= 1'b0;
      end else begin
        a1_out   <= dly;
        a1_valid <= dly_v;
        done     <= dly_v && dly_last;
        if (pop) begin
          rptr     <= rptr + 1'b1;
          a0_out   <= head[WIDTH-1:0];
          a0_valid <= 1'b1;
          dly      <= head[2*WIDTH-1:WIDTH];
          dly_v    <= 1'b1;
          dly_last <= head[2*WIDTH];
        end else begin
          // Zero is the neutral bubble for the MAC array.
          a0_out   <= '0;
          a0_valid <= 1'b0;
          dly      <= '0;
          dly_v    <= 1'b0;
          dly_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
- Input-side skew feeder for the 2x2 Q6.10 systolic MAC array.
- Accepts 2-element activation vectors over a valid/ready handshake and buffers them in a small FIFO.
- Drives the array's two row inputs with the required one-cycle diagonal skew: row 0 gets element 0 at cycle t, row 1 gets element 1 at cycle t+1.
- Stalls with the array and reports end-of-batch.

Parameters:
- WIDTH, 16, element width in bits (Q6.10 fixed point; data is passed through unmodified).
- DEPTH, 4, FIFO depth in vectors; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a vector.
- in_ready  output  1  feeder can accept a vector.
- in_vec  input  2*WIDTH  element k is in_vec[k*WIDTH +: WIDTH].
- in_last  input  1  marks the final vector of a batch.
- stall  input  1  array hold; when 1 the skew pipeline does not advance.
- a0_out  output  WIDTH  row-0 activation to the array.
- a0_valid  output  1  a0_out carries real data.
- a1_out  output  WIDTH  row-1 activation to the array.
- a1_valid  output  1  a1_out carries real data.
- done  output  1  one-cycle pulse when row-1 element of the in_last vector is presented.
- busy  output  1  FIFO non-empty, or a skew/delay register holds valid data.
- count  output  $clog2(DEPTH)+1  FIFO occupancy in vectors.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied; pointers = 0.
  - a0_out, a1_out, all valids, done, busy and count = 0.
  - Delay register and its last flag cleared.
  - in_ready = 0 while rst is high.
  - Reset mid-stream drops all buffered data; no done is produced for the dropped data.
- Handshake:
  - in_ready = !full && !rst.
  - Push occurs when in_valid && in_ready at a rising edge; vector and in_last are stored together.
  - When full, in_ready = 0 even if a pop happens in the same cycle; there is no full-bypass.
- Pop: occurs at an edge when stall=0 and the FIFO is non-empty.
  - Simultaneous push and pop on a non-empty FIFO is legal; count is unchanged.
  - On an empty FIFO there is no fall-through: a vector pushed at edge T is popped at the earliest at edge T+1.
- Skew pipeline, at each edge with stall=0:
  - If popping: a0_out <= v[0]; a0_valid <= 1; dly <= v[1]; dly_v <= 1; dly_last <= last.
  - Else: a0_out <= 0; a0_valid <= 0; dly_v <= 0; dly <= 0. Zeros are the array's neutral bubble.
  - Always: a1_out <= dly; a1_valid <= dly_v; done <= dly_v && dly_last.
- Stall:
  - With stall=1, a0/a1 outputs, valids, dly and the FIFO read side hold their values.
  - Pushes still proceed if not full.
  - done is forced to 0 during stall; a pending done fires on the first unstalled advance.
- Latency, no stall: push at edge T → a0 visible after edge T+1 → a1 and done visible after edge T+2.
- Throughput: one vector per cycle sustained.
- count = wptr - rptr, using the extra pointer MSB for full/empty disambiguation.
- busy = (count != 0) || dly_v || a0_valid || a1_valid.

Test Plan:
- Reset then single vector: push in_vec={0xF300,0x0B00} (elem0=0x0B00), in_last=1 at edge 1.
  - Required: a0_out=0x0B00, a0_valid=1 after edge 2.
  - Required: a1_out=0xF300, a1_valid=1, done=1 after edge 3.
  - Required: all valids and busy = 0 after edge 4.
- Back-to-back stream: push vectors {0x0500,0x0600}, {0x0800,0x0200}, {0xFA00,0x0900} on consecutive edges, last on the third.
  - Required: a0 sequence 0x0600, 0x0200, 0x0900.
  - Required: a1 sequence 0x0500, 0x0800, 0xFA00, one cycle later.
  - Required: no bubbles; done exactly once, coincident with a1=0xFA00.
- Full FIFO: stall=1, push DEPTH=4 vectors.
  - Required: count=4, in_ready=0.
  - A 5th in_valid is not accepted.
  - Release stall: all 4 vectors drain in order; in_ready returns 1 after the first pop.
- Mid-stream stall: stall=1 for 3 cycles while a0=0x0780 and a1=0x1080 are presented.
  - Required: outputs hold those values with valids held.
  - Required: done=0 during stall; the sequence resumes unchanged when stall=0.
- Reset mid-operation: count=3 and dly_v=1, assert rst for one edge.
  - Required: count=0, all outputs 0, no done.
  - A subsequent push {0xFC80,0xE900} emerges with normal T+1/T+2 latency.
